// File: rtl/apb_arbiter2.sv
// apb_arbiter2
// Shares one downstream APB completer between two upstream APB requesters.
// Grants are round-robin when both requesters ask at once. The arbiter builds
// fresh SETUP/ACCESS phases on the shared bus, and a programmable timeout
// force-completes an access that the completer never ends.
//
// Parameters
//   TIMEOUT      maximum ACCESS cycles without out_pready before forced error
//                completion; 0 disables the timeout
// Ports
//   clock        sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   inN_*        upstream APB requester N (N = 0, 1)
//                psel/penable/pwrite/paddr/pwdata/pprot/pstrb are inputs;
//                pready/prdata/pslverr are outputs
//   out_*        shared downstream APB bus toward the completer
//                psel/penable/pwrite/paddr/pwdata/pprot/pstrb are outputs;
//                pready/prdata/pslverr are inputs
//   err_timeout  one-cycle pulse on a forced timeout completion
module apb_arbiter2 #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic [31:0] in0_paddr,
  input  logic [31:0] in0_pwdata,
  input  logic        in0_psel,
  input  logic        in0_penable,
  input  logic        in0_pwrite,
  input  logic [2:0]  in0_pprot,
  input  logic [3:0]  in0_pstrb,
  output logic        in0_pready,
  output logic        in0_pslverr,
  output logic [31:0] in0_prdata,

  input  logic [31:0] in1_paddr,
  input  logic [31:0] in1_pwdata,
  input  logic        in1_psel,
  input  logic        in1_penable,
  input  logic        in1_pwrite,
  input  logic [2:0]  in1_pprot,
  input  logic [3:0]  in1_pstrb,
  output logic        in1_pready,
  output logic        in1_pslverr,
  output logic [31:0] in1_prdata,

  output logic [31:0] out_paddr,
  output logic [31:0] out_pwdata,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [2:0]  out_pprot,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic        out_pslverr,
  input  logic [31:0] out_prdata,

  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last ACCESS-cycle count value before the timeout fires. Only meaningful
  // when the timeout is enabled.
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [31:0] TCNT_LAST  = TIMEOUT_EN ? 32'(TIMEOUT - 1) : 32'd0;

  state_t      state, state_next;
  logic        grant, grant_next;
  logic        last, last_next;
  logic [31:0] tcnt, tcnt_next;

  logic        xfer_done;
  logic        xfer_tmo;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        granted_psel;

  // Upstream penable is not needed: the arbiter generates its own phases.
  logic unused_penable;
  assign unused_penable = in0_penable ^ in1_penable;

  assign xfer_done = (state == ACCESS) && out_pready;
  assign xfer_tmo  = (state == ACCESS) && !out_pready && TIMEOUT_EN &&
                     (tcnt == TCNT_LAST);

  // State register. Reset drops the shared bus at once. Any transfer in
  // flight is abandoned without a response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      tcnt  <= 32'd0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
      tcnt  <= tcnt_next;
    end
  end

  // Next-state logic. The grant is chosen only in IDLE and is then held for
  // the whole transfer. On a tie, the requester that was not served last wins.
  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    tcnt_next  = tcnt;
    case (state)
      IDLE: begin
        if (in0_psel || in1_psel) begin
          state_next = SETUP;
          if (in0_psel && in1_psel) begin
            grant_next = ~last;
          end else begin
            grant_next = in1_psel;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
        tcnt_next  = 32'd0;
      end
      ACCESS: begin
        if (xfer_done || xfer_tmo) begin
          state_next = IDLE;
          last_next  = grant;
        end else begin
          tcnt_next = tcnt + 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic. The shared bus carries the granted requester's fields
  // while a transfer is active and is all-zero in IDLE. The response is
  // returned in the same cycle it arrives. A granted requester that has
  // dropped psel gets no response, so the result is discarded.
  always_comb begin
    out_psel    = 1'b0;
    out_penable = 1'b0;
    out_paddr   = 32'd0;
    out_pwdata  = 32'd0;
    out_pwrite  = 1'b0;
    out_pprot   = 3'd0;
    out_pstrb   = 4'd0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_data   = 32'd0;
    err_timeout = 1'b0;

    if (state != IDLE) begin
      out_psel    = 1'b1;
      out_penable = (state == ACCESS);
      if (grant) begin
        out_paddr  = in1_paddr;
        out_pwdata = in1_pwdata;
        out_pwrite = in1_pwrite;
        out_pprot  = in1_pprot;
        out_pstrb  = in1_pstrb;
      end else begin
        out_paddr  = in0_paddr;
        out_pwdata = in0_pwdata;
        out_pwrite = in0_pwrite;
        out_pprot  = in0_pprot;
        out_pstrb  = in0_pstrb;
      end
    end

    if (xfer_done) begin
      resp_valid = 1'b1;
      resp_err   = out_pslverr;
      resp_data  = out_prdata;
    end else if (xfer_tmo) begin
      resp_valid  = 1'b1;
      resp_err    = 1'b1;
      resp_data   = 32'd0;
      err_timeout = 1'b1;
    end
  end

  // Steer the response to the granted requester only. The other requester
  // sees an all-zero response.
  assign granted_psel = grant ? in1_psel : in0_psel;

  always_comb begin
    in0_pready  = 1'b0;
    in0_pslverr = 1'b0;
    in0_prdata  = 32'd0;
    in1_pready  = 1'b0;
    in1_pslverr = 1'b0;
    in1_prdata  = 32'd0;
    if (resp_valid && granted_psel) begin
      if (grant) begin
        in1_pready  = 1'b1;
        in1_pslverr = resp_err;
        in1_prdata  = resp_data;
      end else begin
        in0_pready  = 1'b1;
        in0_pslverr = resp_err;
        in0_prdata  = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter2.sv
// tb_apb_arbiter2
// Testbench for apb_arbiter2 with TIMEOUT = 16.
//
// Each requester transfer pushes its expected response onto that
// requester's queue. The test also pushes the expected completion order.
// A negedge monitor pops these queues whenever a response appears. The
// completer model answers after a programmable number of wait cycles, and it
// can also stall forever. Its read data is the address XORed with a key.
module tb_apb_arbiter2;

  localparam logic [31:0] KEY = 32'hDEAD_AEEF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic [31:0] in0_paddr = '0, in0_pwdata = '0;
  logic        in0_psel = 1'b0, in0_penable = 1'b0, in0_pwrite = 1'b0;
  logic [2:0]  in0_pprot = '0;
  logic [3:0]  in0_pstrb = '0;
  logic        in0_pready, in0_pslverr;
  logic [31:0] in0_prdata;

  logic [31:0] in1_paddr = '0, in1_pwdata = '0;
  logic        in1_psel = 1'b0, in1_penable = 1'b0, in1_pwrite = 1'b0;
  logic [2:0]  in1_pprot = '0;
  logic [3:0]  in1_pstrb = '0;
  logic        in1_pready, in1_pslverr;
  logic [31:0] in1_prdata;

  logic [31:0] out_paddr, out_pwdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready, out_pslverr;
  logic [31:0] out_prdata;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  int wait_cfg = 0;
  bit stall = 1'b0;
  bit err_cfg = 1'b0;
  int acc_cnt;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int          order_q[$];
  logic [64:0] bus_q[$];
  bit          check_bus = 1'b0;
  int          psel_cycles = 0;
  int          tmo_pulses = 0;

  always #5 clock = ~clock;

  apb_arbiter2 #(.TIMEOUT(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in0_paddr   (in0_paddr),
    .in0_pwdata  (in0_pwdata),
    .in0_psel    (in0_psel),
    .in0_penable (in0_penable),
    .in0_pwrite  (in0_pwrite),
    .in0_pprot   (in0_pprot),
    .in0_pstrb   (in0_pstrb),
    .in0_pready  (in0_pready),
    .in0_pslverr (in0_pslverr),
    .in0_prdata  (in0_prdata),
    .in1_paddr   (in1_paddr),
    .in1_pwdata  (in1_pwdata),
    .in1_psel    (in1_psel),
    .in1_penable (in1_penable),
    .in1_pwrite  (in1_pwrite),
    .in1_pprot   (in1_pprot),
    .in1_pstrb   (in1_pstrb),
    .in1_pready  (in1_pready),
    .in1_pslverr (in1_pslverr),
    .in1_prdata  (in1_prdata),
    .out_paddr   (out_paddr),
    .out_pwdata  (out_pwdata),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pwrite  (out_pwrite),
    .out_pprot   (out_pprot),
    .out_pstrb   (out_pstrb),
    .out_pready  (out_pready),
    .out_pslverr (out_pslverr),
    .out_prdata  (out_prdata),
    .err_timeout (err_timeout)
  );

  // The completer counts ACCESS wait cycles and answers once wait_cfg cycles
  // have passed, unless it is set to stall.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt <= 0;
    end else if (out_psel && out_penable && !out_pready) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  assign out_pready  = out_psel && out_penable && !stall && (acc_cnt >= wait_cfg);
  assign out_prdata  = out_pready ? (out_paddr ^ KEY) : 32'h0;
  assign out_pslverr = out_pready && err_cfg;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // The monitor samples on the falling edge. It checks each response against
  // the scoreboard, and in bus-check mode it checks each SETUP phase too.
  always @(negedge clock) begin : monitor
    logic [32:0] e;
    logic [64:0] b;
    int          id;
    if (reset_n) begin
      if (out_psel) psel_cycles <= psel_cycles + 1;
      if (err_timeout) tmo_pulses <= tmo_pulses + 1;
      if (in0_pready || in1_pready) begin
        checkOutput("both_pready", 32'(in0_pready & in1_pready), 32'd0);
        if (order_q.size() == 0) begin
          checkOutput("order_underflow", 32'd1, 32'd0);
        end else begin
          id = order_q.pop_front();
          checkOutput("grant_order", in1_pready ? 32'd1 : 32'd0, 32'(id));
        end
        if (in0_pready) begin
          if (exp_q0.size() == 0) begin
            checkOutput("exp0_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q0.pop_front();
            checkOutput("in0_prdata", in0_prdata, e[31:0]);
            checkOutput("in0_pslverr", 32'(in0_pslverr), 32'(e[32]));
          end
        end
        if (in1_pready) begin
          if (exp_q1.size() == 0) begin
            checkOutput("exp1_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q1.pop_front();
            checkOutput("in1_prdata", in1_prdata, e[31:0]);
            checkOutput("in1_pslverr", 32'(in1_pslverr), 32'(e[32]));
          end
        end
      end
      if (check_bus && out_psel && !out_penable) begin
        if (bus_q.size() == 0) begin
          checkOutput("bus_underflow", 32'd1, 32'd0);
        end else begin
          b = bus_q.pop_front();
          checkOutput("out_pwrite", 32'(out_pwrite), 32'(b[64]));
          checkOutput("out_paddr", out_paddr, b[63:32]);
          checkOutput("out_pwdata", out_pwdata, b[31:0]);
        end
      end
    end
  end

  // Drive one APB transfer from requester id, starting on a falling edge.
  // lat counts falling edges from the SETUP drive to the pready sample.
  // The task returns on the falling edge after completion, with psel low.
  task automatic applyStimulus(input int id, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic wr,
                               output int lat);
    logic [32:0] e;
    bit          rdy;
    e = stall ? {1'b1, 32'h0} : {err_cfg, addr ^ KEY};
    if (id == 0) begin
      exp_q0.push_back(e);
      in0_paddr = addr; in0_pwdata = wdata; in0_pwrite = wr;
      in0_pprot = 3'd2; in0_pstrb = 4'hF;
      in0_psel = 1'b1; in0_penable = 1'b0;
    end else begin
      exp_q1.push_back(e);
      in1_paddr = addr; in1_pwdata = wdata; in1_pwrite = wr;
      in1_pprot = 3'd1; in1_pstrb = 4'h3;
      in1_psel = 1'b1; in1_penable = 1'b0;
    end
    @(negedge clock);
    if (id == 0) in0_penable = 1'b1; else in1_penable = 1'b1;
    lat = 1;
    rdy = 1'b0;
    while (!rdy && lat < 100) begin
      @(negedge clock);
      lat++;
      rdy = (id == 0) ? in0_pready : in1_pready;
    end
    if (!rdy) checkOutput("ready_bound", 32'd0, 32'd1);
    @(negedge clock);
    if (id == 0) begin
      in0_psel = 1'b0; in0_penable = 1'b0;
    end else begin
      in1_psel = 1'b0; in1_penable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat0, lat1, base, tbase;

    // Check the outputs while reset is held.
    repeat (2) @(negedge clock);
    checkOutput("rst_out_psel", 32'(out_psel), 32'd0);
    checkOutput("rst_out_penable", 32'(out_penable), 32'd0);
    checkOutput("rst_out_paddr", out_paddr, 32'd0);
    checkOutput("rst_in0_pready", 32'(in0_pready), 32'd0);
    checkOutput("rst_in1_pready", 32'(in1_pready), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Simultaneous requests right after reset: in0 first, then in1.
    $display("[TB] simultaneous requests after reset");
    order_q.push_back(0);
    order_q.push_back(1);
    fork
      applyStimulus(0, 32'h0000_0100, 32'h0, 1'b0, lat0);
      applyStimulus(1, 32'h0000_0200, 32'h0, 1'b0, lat1);
    join
    checkOutput("sim_lat0", 32'(lat0), 32'd2);
    checkOutput("sim_lat1", 32'(lat1), 32'd5);

    // Single read with a zero-wait completer.
    $display("[TB] single read");
    base = psel_cycles;
    order_q.push_back(0);
    applyStimulus(0, 32'h0000_1000, 32'h0, 1'b0, lat0);
    checkOutput("single_lat", 32'(lat0), 32'd2);
    checkOutput("single_psel_cycles", 32'(psel_cycles - base), 32'd2);
    checkOutput("single_idle_psel", 32'(out_psel), 32'd0);

    // Five wait states followed by an error response.
    $display("[TB] wait states with slave error");
    wait_cfg = 5;
    err_cfg  = 1'b1;
    tbase    = tmo_pulses;
    order_q.push_back(1);
    applyStimulus(1, 32'h0000_4000, 32'h0, 1'b0, lat1);
    checkOutput("wait_lat", 32'(lat1), 32'd7);
    checkOutput("wait_no_timeout", 32'(tmo_pulses - tbase), 32'd0);
    wait_cfg = 0;
    err_cfg  = 1'b0;

    // Back-to-back writes from both requesters: grants alternate.
    $display("[TB] round-robin fairness");
    for (int i = 0; i < 4; i++) begin
      order_q.push_back(0);
      order_q.push_back(1);
      bus_q.push_back({1'b1, 32'h2000 + 32'(i * 4), 32'h1111_0000 + 32'(i)});
      bus_q.push_back({1'b1, 32'h3000 + 32'(i * 4), 32'h2222_0000 + 32'(i)});
    end
    check_bus = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(0, 32'h2000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b1, lat0);
      end
      begin
        for (int j = 0; j < 4; j++)
          applyStimulus(1, 32'h3000 + 32'(j * 4), 32'h2222_0000 + 32'(j), 1'b1, lat1);
      end
    join
    check_bus = 1'b0;
    checkOutput("rr_bus_left", 32'(bus_q.size()), 32'd0);
    checkOutput("rr_order_left", 32'(order_q.size()), 32'd0);

    // A completer that never answers: forced completion on ACCESS cycle 16.
    $display("[TB] access timeout");
    stall = 1'b1;
    tbase = tmo_pulses;
    order_q.push_back(1);
    applyStimulus(1, 32'h0000_5000, 32'h0, 1'b0, lat1);
    checkOutput("tmo_lat", 32'(lat1), 32'd17);
    checkOutput("tmo_pulses", 32'(tmo_pulses - tbase), 32'd1);
    checkOutput("tmo_psel_after", 32'(out_psel), 32'd0);
    checkOutput("tmo_err_low", 32'(err_timeout), 32'd0);

    // Reset asserted during ACCESS aborts the transfer at once.
    $display("[TB] reset during access");
    in0_paddr = 32'h0000_6000; in0_pwrite = 1'b0;
    in0_psel = 1'b1; in0_penable = 1'b0;
    @(negedge clock);
    in0_penable = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("pre_rst_penable", 32'(out_penable), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_psel", 32'(out_psel), 32'd0);
    checkOutput("mid_rst_penable", 32'(out_penable), 32'd0);
    checkOutput("mid_rst_paddr", out_paddr, 32'd0);
    checkOutput("mid_rst_pready", 32'(in0_pready), 32'd0);
    @(negedge clock);
    in0_psel = 1'b0; in0_penable = 1'b0;
    stall = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // After release, arbitration starts again from its power-on state.
    order_q.push_back(0);
    order_q.push_back(1);
    fork
      applyStimulus(0, 32'h0000_7000, 32'h0, 1'b0, lat0);
      applyStimulus(1, 32'h0000_7100, 32'h0, 1'b0, lat1);
    join
    checkOutput("post_rst_lat0", 32'(lat0), 32'd2);
    checkOutput("post_rst_lat1", 32'(lat1), 32'd5);

    repeat (2) @(negedge clock);
    checkOutput("exp0_left", 32'(exp_q0.size()), 32'd0);
    checkOutput("exp1_left", 32'(exp_q1.size()), 32'd0);
    checkOutput("order_left", 32'(order_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter2.md
# apb_arbiter2

Two-requester APB arbiter that shares one downstream APB completer (for example a peripheral behind the APB delayer) between two upstream APB requesters. It runs a round-robin grant policy and regenerates clean SETUP/ACCESS phases on the shared bus. It also applies a programmable access timeout, so that a hung completer cannot stall the interconnect. It sits between the SoC APB fabric masters (CPU-side bridge, DMA) and a single APB slave chain.

## Interface
- TIMEOUT, 4096: maximum ACCESS cycles without out_pready before forced error completion; 0 disables the timeout.
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- inN_paddr, inN_pwdata  input  32  address / write data of requester N (N=0,1).
- inN_psel, inN_penable, inN_pwrite  input  1  APB control of requester N.
- inN_pprot  input  3  protection of requester N.
- inN_pstrb  input  4  write strobes of requester N.
- inN_pready, inN_pslverr  output  1  completion / error to requester N.
- inN_prdata  output  32  read data to requester N.
- out_paddr, out_pwdata  output  32  shared-bus address / write data.
- out_psel, out_penable, out_pwrite  output  1  shared-bus control.
- out_pprot  output  3  shared-bus protection.
- out_pstrb  output  4  shared-bus strobes.
- out_pready, out_pslverr  input  1  completer response.
- out_prdata  input  32  completer read data.
- err_timeout  output  1  one-cycle pulse when a forced timeout completion occurs.

## Operation
- FSM states: IDLE, SETUP, ACCESS. Registers: grant (1 bit), last (1 bit, reset 1), tcnt (32 bit).
- IDLE:
  - A request is inN_psel=1.
  - If only one requester is requesting, grant that requester.
  - If both are requesting, grant !last.
  - With any request present, go to SETUP; otherwise stay in IDLE.
- SETUP: out_psel=1, out_penable=0; always go to ACCESS next cycle; tcnt cleared to 0.
- ACCESS: out_psel=1, out_penable=1.
  - Normal completion: out_pready=1 → in{grant}_pready=1, in{grant}_prdata=out_prdata, in{grant}_pslverr=out_pslverr (combinational, same cycle); last<=grant; go to IDLE.
  - Wait: out_pready=0 and (TIMEOUT==0 or tcnt!=TIMEOUT-1) → tcnt<=tcnt+1; stay in ACCESS.
  - Forced completion: TIMEOUT!=0, out_pready=0 and tcnt==TIMEOUT-1 → in{grant}_pready=1, in{grant}_pslverr=1, in{grant}_prdata=0, err_timeout=1; last<=grant; go to IDLE. out_psel drops the next cycle.
- out_paddr/pwdata/pwrite/pstrb/pprot are muxed from in{grant} in SETUP and ACCESS, and are 0 in IDLE.
- Non-granted requester: pready=0, prdata=0, pslverr=0 at all times. It waits in its own ACCESS phase indefinitely, which is legal APB.
- inN_penable is not used for sequencing; the arbiter regenerates phases itself.
- Granted requester dropping psel mid-transfer (protocol violation): the shared transfer still runs to completion or timeout, and the response is discarded.

## Timing
- Reset (reset_n=0, asynchronous) puts the block in IDLE with grant=0, last=1, tcnt=0.
- Outputs during reset: out_psel=out_penable=0, all out_* data 0, all inN_pready/prdata/pslverr=0, err_timeout=0.
- Reset mid-transfer aborts immediately. out_psel falls asynchronously, and no response is given to the requester.
- Latency: requester SETUP at cycle t → arbiter SETUP t+1 → ACCESS t+2. Earliest inN_pready is at t+2, i.e. one extra wait state versus a direct connection.
- Completion at cycle c → IDLE at c+1. The next grant's SETUP is at c+2 at the earliest, so the shared bus has one idle cycle between transfers.
- A request arriving in the same cycle the other requester completes is seen in IDLE and wins if it is !last.
- Timeout: with out_pready held 0, forced completion occurs at the TIMEOUT-th ACCESS cycle (ACCESS cycles numbered 1..TIMEOUT).
- tcnt never wraps, because TIMEOUT ≤ 2^32-1.

## Test plan
- Single read: in0 reads 0x1000 and the completer returns 0xDEADBEEF with zero wait → in0_pready at t+2 with prdata=0xDEADBEEF; out_psel high for exactly 2 cycles.
- Simultaneous requests after reset: in0 and in1 both assert psel at the same cycle → in0 is served first (last=1 at reset), then in1; in1_pready stays 0 throughout in0's transfer.
- Round-robin fairness: both requesters issue back-to-back writes continuously for 8 transfers → grants alternate 0,1,0,1,…; out_paddr/pwdata match the granted requester each time.
- Wait states and error: the completer stalls 5 cycles, then returns pslverr=1 → in1_pready after 6 ACCESS cycles with pslverr=1; err_timeout stays 0.
- Timeout with TIMEOUT=16 and out_pready tied 0 → at the 16th ACCESS cycle the requester sees pready=1, pslverr=1, prdata=0, and err_timeout pulses once; the next cycle out_psel=0.
- reset_n asserted during ACCESS → out_psel=0 immediately, no pready pulse; after release the first transfer behaves as after power-on.
